// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings, the
// FSM state type, the latched-request record and byte-mask/legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FIRST  = 2'd1,
    S_SECOND = 2'd2,
    S_RESP   = 2'd3
  } lsu_state_e;

  // Request fields held for the whole transaction. The word address is kept
  // separately in the top because its width follows ADDR_W.
  typedef struct packed {
    logic        store;
    logic [2:0]  funct3;
    logic [1:0]  offset;
    logic [31:0] wdata;
  } lsu_req_t;

  // Byte mask across two adjacent words: [3:0] first word, [7:4] second.
  function automatic logic [7:0] lsu_mask8(input logic [2:0] funct3,
                                           input logic [1:0] offset);
    logic [7:0] base;
    case (funct3[1:0])
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      default: base = 8'h0f;
    endcase
    return base << offset;
  endfunction

  function automatic logic lsu_legal(input logic store, input logic [2:0] funct3);
    logic ok;
    ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    if (!store) ok = ok || (funct3 == F3_BU) || (funct3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: shifts the two-word window right by the byte offset,
// truncates to the access size and sign- or zero-extends.
//   data   in  64  {hi word, lo word}
//   offset in  2   byte offset of the access within the lo word
//   funct3 in  3   RV32I load funct3
//   result out 32  extended load value (0 for an unknown funct3)
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] sh;
  assign sh = 32'(data >> {offset, 3'b000});

  always_comb begin
    result = '0;
    case (funct3)
      F3_B:    result = {{24{sh[7]}}, sh[7:0]};
      F3_H:    result = {{16{sh[15]}}, sh[15:0]};
      F3_W:    result = sh;
      F3_BU:   result = {24'b0, sh[7:0]};
      F3_HU:   result = {16'b0, sh[15:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-wide data memory. One request in
// flight; accesses crossing a word boundary are split into two memory cycles.
//   clk, rst_n             clock, async active-low reset
//   req_valid/req_ready    request handshake from the execute stage
//   req_store/funct3/addr/wdata  request payload, sampled on accept only
//   resp_valid/rdata/err   one-cycle registered completion pulse
//   mem_addr/we/be/wdata   word address, write strobe, lanes, aligned data
//   mem_rdata              combinational read data for mem_addr
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state, state_nxt;
  lsu_req_t          req_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       lo_q;
  logic [7:0]        m8;
  logic [63:0]       wsh;
  logic [63:0]       align_data;
  logic [31:0]       align_res;
  logic              accept;
  logic              crosses;
  logic              unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_W+2];

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign m8        = lsu_mask8(req_q.funct3, req_q.offset);
  assign crosses   = |m8[7:4];
  assign wsh       = {32'b0, req_q.wdata} << {req_q.offset, 3'b000};

  // The hi word is never stored: in SECOND it is taken straight from the
  // memory, so the result can be registered on the edge that ends the access.
  assign align_data = (state == S_SECOND) ? {mem_rdata, lo_q} : {32'b0, mem_rdata};

  lsu_load_align u_align (
    .data   (align_data),
    .offset (req_q.offset),
    .funct3 (req_q.funct3),
    .result (align_res)
  );

  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_be    = 4'b0;
    mem_wdata = '0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = lsu_legal(req_store, req_funct3) ? S_FIRST : S_RESP;
      end
      S_FIRST: begin
        mem_addr  = waddr_q;
        mem_be    = m8[3:0];
        mem_wdata = wsh[31:0];
        mem_we    = req_q.store;
        state_nxt = crosses ? S_SECOND : S_RESP;
      end
      S_SECOND: begin
        mem_addr  = waddr_q + ADDR_W'(1);   // wraps at the top of memory
        mem_be    = m8[7:4];
        mem_wdata = wsh[63:32];
        mem_we    = req_q.store;
        state_nxt = S_RESP;
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      req_q      <= '0;
      waddr_q    <= '0;
      lo_q       <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      resp_valid <= (state_nxt == S_RESP);
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_q.store  <= req_store;
            req_q.funct3 <= req_funct3;
            req_q.offset <= req_addr[1:0];
            req_q.wdata  <= req_wdata;
            waddr_q      <= req_addr[ADDR_W+1:2];
            resp_err     <= !lsu_legal(req_store, req_funct3);
          end
        end
        S_FIRST: begin
          lo_q <= mem_rdata;
          if (!req_q.store && !crosses) resp_rdata <= align_res;
        end
        S_SECOND: begin
          if (!req_q.store) resp_rdata <= align_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-lane word memory model.
module tb_load_store_unit;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_store = 1'b0;
  logic [2:0]        req_funct3 = 3'b0;
  logic [31:0]       req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Per-transaction observations
  logic [ADDR_W-1:0] la [4];
  logic [3:0]        lb [4];
  logic              lw [4];
  logic [31:0]       ld [4];
  int                nm, lat;
  logic [31:0]       rd;
  logic              re, busy_rdy;

  task automatic issue(input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    // Scramble the request bus: the unit must have latched on the accept edge.
    req_valid = 1'b0; req_store = ~st; req_funct3 = 3'b111;
    req_addr = $urandom; req_wdata = $urandom;
    nm = 0; lat = 0; rd = '0; re = 1'b0; busy_rdy = 1'b1;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) busy_rdy = req_ready;
      if (mem_we || mem_be != 4'b0) begin
        if (nm < 4) begin
          la[nm] = mem_addr; lb[nm] = mem_be; lw[nm] = mem_we; ld[nm] = mem_wdata;
        end
        nm++;
      end
      if (resp_valid) begin
        lat = c; rd = resp_rdata; re = resp_err;
      end
    end
    checks++;
    assert (lat != 0) else begin
      errors++;
      $error("FAIL resp_timeout: observed no resp_valid within 8 cycles, required one");
    end
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk); rst_n = 1'b1;

    // Aligned store word
    issue(1'b1, 3'b010, 32'h010, 32'hDEADBEEF);
    chk("sw_nmem", nm, 1);
    chk("sw_addr", la[0], 4);
    chk("sw_be", lb[0], 4'hF);
    chk("sw_we", lw[0], 1);
    chk("sw_wdata", ld[0], 32'hDEADBEEF);
    chk("sw_lat", lat, 2);
    chk("sw_err", re, 0);
    chk("sw_rdata", rd, 0);
    chk("sw_busy_ready", busy_rdy, 0);
    chk("sw_mem4", mem[4], 32'hDEADBEEF);

    issue(1'b0, 3'b010, 32'h010, 32'h0);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_lat", lat, 2);
    chk("lw_we", lw[0], 0);

    // Byte/half extraction and extension
    issue(1'b1, 3'b010, 32'h010, 32'h80FF7F01);
    issue(1'b0, 3'b000, 32'h013, 32'h0);
    chk("lb_13", rd, 32'hFFFFFF80);
    chk("lb_13_be", lb[0], 4'b1000);
    issue(1'b0, 3'b100, 32'h013, 32'h0);
    chk("lbu_13", rd, 32'h00000080);
    issue(1'b0, 3'b001, 32'h012, 32'h0);
    chk("lh_12", rd, 32'hFFFF80FF);
    issue(1'b0, 3'b101, 32'h010, 32'h0);
    chk("lhu_10", rd, 32'h00007F01);
    issue(1'b0, 3'b000, 32'h011, 32'h0);
    chk("lb_11", rd, 32'h0000007F);

    // Halfword store crossing a word boundary
    issue(1'b1, 3'b001, 32'h023, 32'h0000ABCD);
    chk("sh_nmem", nm, 2);
    chk("sh_a0", la[0], 8);
    chk("sh_be0", lb[0], 4'b1000);
    chk("sh_wd0", ld[0], 32'hCD000000);
    chk("sh_a1", la[1], 9);
    chk("sh_be1", lb[1], 4'b0001);
    chk("sh_wd1", ld[1], 32'h000000AB);
    chk("sh_lat", lat, 3);
    chk("sh_mem8", mem[8][31:24], 8'hCD);
    chk("sh_mem9", mem[9][7:0], 8'hAB);
    issue(1'b0, 3'b101, 32'h023, 32'h0);
    chk("lhu_23", rd, 32'h0000ABCD);
    chk("lhu_23_lat", lat, 3);
    issue(1'b0, 3'b001, 32'h023, 32'h0);
    chk("lh_23", rd, 32'hFFFFABCD);

    // Misaligned word load wrapping past the last word
    issue(1'b1, 3'b010, 32'h3FFC, 32'h44332211);
    issue(1'b1, 3'b010, 32'h0000, 32'h88776655);
    issue(1'b0, 3'b010, 32'h3FFD, 32'h0);
    chk("wrap_nmem", nm, 2);
    chk("wrap_a0", la[0], 12'hFFF);
    chk("wrap_be0", lb[0], 4'b1110);
    chk("wrap_a1", la[1], 0);
    chk("wrap_be1", lb[1], 4'b0001);
    chk("wrap_rdata", rd, 32'h55443322);
    chk("wrap_lat", lat, 3);

    // Illegal funct3
    issue(1'b0, 3'b011, 32'h010, 32'h0);
    chk("ill_ld_nmem", nm, 0);
    chk("ill_ld_lat", lat, 1);
    chk("ill_ld_err", re, 1);
    chk("ill_ld_rdata", rd, 0);
    @(negedge clk);
    chk("resp_drop_valid", resp_valid, 0);
    chk("resp_drop_err", resp_err, 0);
    issue(1'b1, 3'b100, 32'h010, 32'h0);
    chk("ill_st_nmem", nm, 0);
    chk("ill_st_err", re, 1);
    chk("ill_st_lat", lat, 1);
    chk("ill_st_mem4", mem[4], 32'h80FF7F01);

    // Reset during SECOND of a crossing store
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h031; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mrst_first_addr", mem_addr, 12);
    chk("mrst_first_be", mem_be, 4'b1110);
    @(negedge clk);
    chk("mrst_second_addr", mem_addr, 13);
    chk("mrst_second_be", mem_be, 4'b0001);
    rst_n = 1'b0;
    #1;
    chk("mrst_we", mem_we, 0);
    chk("mrst_be", mem_be, 0);
    chk("mrst_addr", mem_addr, 0);
    chk("mrst_wdata", mem_wdata, 0);
    chk("mrst_ready", req_ready, 1);
    chk("mrst_valid", resp_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mrst_no_resp", resp_valid, 0);
    end
    issue(1'b0, 3'b010, 32'h010, 32'h0);
    chk("post_rst_rdata", rd, 32'h80FF7F01);
    chk("post_rst_lat", lat, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
